// File: rtl/vc_router_pkg.sv
// Shared definitions for the VC credit controller.
//   vc_state_t : per-(port,VC) lifecycle FREE -> ACTIVE -> (DRAIN) -> FREE
//   *_DEF      : default NUM_PORTS / NUM_VCS / BUF_DEPTH
//   idx_width  : width of a VC index field, never narrower than one bit
package vc_router_pkg;

    localparam int NUM_PORTS_DEF = 5;
    localparam int NUM_VCS_DEF   = 4;
    localparam int BUF_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        ACTIVE = 2'b01,
        DRAIN  = 2'b10
    } vc_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vc_credit_counter.sv
// One VC of one output port: downstream credit counter plus FREE/ACTIVE/DRAIN state.
// Optional macro: VC_CREDIT_ERR_EN enables err_event; otherwise err_event is 0.
// Ports:
//   clk, reset       : clock, asynchronous active-low reset
//   alloc_hit        : allocator grants this VC
//   send_hit         : a flit leaves on this VC, send_tail marks a tail flit
//   credit_hit       : downstream returns one credit to this VC
//   free             : VC is FREE (registered)
//   has_credit       : counter > 0 (registered)
//   err_event        : single-cycle indication of an illegal event this cycle
module vc_credit_counter
    import vc_router_pkg::*;
#(
    parameter int BUF_DEPTH = BUF_DEPTH_DEF,
    parameter int CNT_W     = $clog2(BUF_DEPTH_DEF + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic alloc_hit,
    input  logic send_hit,
    input  logic send_tail,
    input  logic credit_hit,
    output logic free,
    output logic has_credit,
    output logic err_event
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

    vc_state_t        state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             send_ok;
    logic             credit_ok;

    always_comb begin
        // A send needs an allocated VC and a credit in hand.
        send_ok   = send_hit && (state_reg != FREE) && (count_reg != '0);
        // A credit at a full counter is only legal when a send frees a slot in the same cycle.
        credit_ok = credit_hit && ((count_reg != FULL) || send_ok);

        count_next = count_reg;
        if (send_ok && !credit_ok) begin
            count_next = count_reg - CNT_W'(1);
        end else if (credit_ok && !send_ok) begin
            count_next = count_reg + CNT_W'(1);
        end

        // Allocation is only looked at in FREE, so a tail send on an ACTIVE VC
        // always wins over an allocation of that VC in the same cycle.
        state_next = state_reg;
        case (state_reg)
            FREE: begin
                if (alloc_hit) state_next = ACTIVE;
            end
            ACTIVE: begin
                if (send_ok && send_tail) state_next = (count_next == FULL) ? FREE : DRAIN;
            end
            DRAIN: begin
                if (count_next == FULL) state_next = FREE;
            end
            default: state_next = FREE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= FREE;
            count_reg <= FULL;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    assign free       = (state_reg == FREE);
    assign has_credit = (count_reg != '0);

`ifdef VC_CREDIT_ERR_EN
    assign err_event = (alloc_hit && (state_reg != FREE))
                     || (send_hit && !send_ok)
                     || (credit_hit && !credit_ok);
`else
    assign err_event = 1'b0;
`endif

endmodule

// File: rtl/vc_credit_ctrl.sv
// Credit and VC-availability tracker for all output ports of a router.
// Optional macro: VC_CREDIT_ERR_EN enables the sticky protocol-error flag;
// without it err stays 0 while illegal events are still ignored.
// Ports (per-port fields packed with port p at [p*VC_W +: VC_W]):
//   clk, reset               : clock, asynchronous active-low reset
//   alloc_valid / alloc_vc   : VC granted on port p
//   send_valid / send_vc     : flit sent on port p, send_tail marks tail flit
//   credit_valid / credit_vc : credit returned on port p
//   vc_availability          : bit p*NUM_VCS+v = 1 when VC is FREE
//   credit_avail             : bit p*NUM_VCS+v = 1 when credit count > 0
//   err                      : sticky protocol-error flag
module vc_credit_ctrl
    import vc_router_pkg::*;
#(
    parameter  int NUM_PORTS = NUM_PORTS_DEF,
    parameter  int NUM_VCS   = NUM_VCS_DEF,
    parameter  int BUF_DEPTH = BUF_DEPTH_DEF,
    localparam int VC_W      = idx_width(NUM_VCS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_PORTS-1:0]         alloc_valid,
    input  logic [NUM_PORTS*VC_W-1:0]    alloc_vc,
    input  logic [NUM_PORTS-1:0]         send_valid,
    input  logic [NUM_PORTS*VC_W-1:0]    send_vc,
    input  logic [NUM_PORTS-1:0]         send_tail,
    input  logic [NUM_PORTS-1:0]         credit_valid,
    input  logic [NUM_PORTS*VC_W-1:0]    credit_vc,
    output logic [NUM_VCS*NUM_PORTS-1:0] vc_availability,
    output logic [NUM_VCS*NUM_PORTS-1:0] credit_avail,
    output logic                         err
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    logic [NUM_VCS*NUM_PORTS-1:0] err_vec;
    logic                         err_reg;

    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            for (gj = 0; gj < NUM_VCS; gj++) begin : g_vc
                logic alloc_hit, send_hit, credit_hit;

                assign alloc_hit  = alloc_valid[gi]  && (alloc_vc[gi*VC_W +: VC_W]  == VC_W'(gj));
                assign send_hit   = send_valid[gi]   && (send_vc[gi*VC_W +: VC_W]   == VC_W'(gj));
                assign credit_hit = credit_valid[gi] && (credit_vc[gi*VC_W +: VC_W] == VC_W'(gj));

                vc_credit_counter #(
                    .BUF_DEPTH (BUF_DEPTH),
                    .CNT_W     (CNT_W)
                ) u_cnt (
                    .clk        (clk),
                    .reset      (reset),
                    .alloc_hit  (alloc_hit),
                    .send_hit   (send_hit),
                    .send_tail  (send_tail[gi]),
                    .credit_hit (credit_hit),
                    .free       (vc_availability[gi*NUM_VCS + gj]),
                    .has_credit (credit_avail[gi*NUM_VCS + gj]),
                    .err_event  (err_vec[gi*NUM_VCS + gj])
                );
            end
        end
    endgenerate

    // err_vec is constant zero when error checking is compiled out, so this
    // register collapses to a tied-off 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_reg | (|err_vec);
        end
    end

    assign err = err_reg;

endmodule

// File: tb/tb_vc_credit_ctrl.sv
// Scoreboard bench for vc_credit_ctrl (5 ports x 4 VCs x 4 credits).
// Stimulus is applied on the falling edge and the expected registered outputs
// are queued; the monitor pops one entry after each rising edge and compares.
module tb_vc_credit_ctrl;

`ifdef VC_CREDIT_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    localparam logic [19:0] ALL = 20'hFFFFF;

    logic        clk;
    logic        reset;
    logic [4:0]  alloc_valid;
    logic [9:0]  alloc_vc;
    logic [4:0]  send_valid;
    logic [9:0]  send_vc;
    logic [4:0]  send_tail;
    logic [4:0]  credit_valid;
    logic [9:0]  credit_vc;
    logic [19:0] vc_availability;
    logic [19:0] credit_avail;
    logic        err;

    vc_credit_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .alloc_valid     (alloc_valid),
        .alloc_vc        (alloc_vc),
        .send_valid      (send_valid),
        .send_vc         (send_vc),
        .send_tail       (send_tail),
        .credit_valid    (credit_valid),
        .credit_vc       (credit_vc),
        .vc_availability (vc_availability),
        .credit_avail    (credit_avail),
        .err             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [19:0] av;
        logic [19:0] ca;
        logic        e;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks   = 0;
    int    failures = 0;

    logic [19:0] ex_av;
    logic [19:0] ex_ca;
    logic        ex_err;

    task automatic begin_cyc();
        @(negedge clk);
        alloc_valid  = '0;
        alloc_vc     = '0;
        send_valid   = '0;
        send_vc      = '0;
        send_tail    = '0;
        credit_valid = '0;
        credit_vc    = '0;
    endtask

    task automatic do_alloc(input int p, input int v);
        alloc_valid[p]     = 1'b1;
        alloc_vc[p*2 +: 2] = 2'(v);
    endtask

    task automatic do_send(input int p, input int v, input logic tail);
        send_valid[p]     = 1'b1;
        send_vc[p*2 +: 2] = 2'(v);
        send_tail[p]      = tail;
    endtask

    task automatic do_credit(input int p, input int v);
        credit_valid[p]     = 1'b1;
        credit_vc[p*2 +: 2] = 2'(v);
    endtask

    task automatic push(input string name);
        exp_t e;
        e.av = ex_av;
        e.ca = ex_ca;
        e.e  = ex_err;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    // Monitor: one comparison set per rising edge that has a queued expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                exp_t  e;
                string n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                $display("txn %-14s av=%h ca=%h err=%b", n, vc_availability, credit_avail, err);
                checks++;
                if (vc_availability !== e.av) begin
                    failures++;
                    $display("FAIL %s vc_availability got=%h exp=%h", n, vc_availability, e.av);
                end
                checks++;
                if (credit_avail !== e.ca) begin
                    failures++;
                    $display("FAIL %s credit_avail got=%h exp=%h", n, credit_avail, e.ca);
                end
                checks++;
                if (err !== e.e) begin
                    failures++;
                    $display("FAIL %s err got=%b exp=%b", n, err, e.e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b0;
        ex_av  = ALL;
        ex_ca  = ALL;
        ex_err = 1'b0;

        // Reset and idle.
        begin_cyc(); push("reset_a");
        begin_cyc(); push("reset_b");
        begin_cyc(); reset = 1'b1; push("idle");

        // Allocations on four ports in one cycle.
        begin_cyc();
        do_alloc(0, 0); do_alloc(4, 3); do_alloc(1, 2); do_alloc(3, 0);
        ex_av[0] = 1'b0; ex_av[19] = 1'b0; ex_av[6] = 1'b0; ex_av[12] = 1'b0;
        push("alloc_multi");

        // p0v0 ->3, p4v3 ->3, p1v2 tail ->3 DRAIN, p3v0 tail+credit stays 4 -> FREE.
        begin_cyc();
        do_send(0, 0, 1'b0); do_send(4, 3, 1'b0); do_send(1, 2, 1'b1);
        do_send(3, 0, 1'b1); do_credit(3, 0);
        ex_av[12] = 1'b1;
        push("mixed1");

        // p0v0 ->2, p4v3 ->2, p1v2 credit ->4 leaves DRAIN.
        begin_cyc();
        do_send(0, 0, 1'b0); do_send(4, 3, 1'b0); do_credit(1, 2);
        ex_av[6] = 1'b1;
        push("mixed2");

        // p0v0 ->1, p4v3 send+credit net zero stays 2.
        begin_cyc();
        do_send(0, 0, 1'b0); do_send(4, 3, 1'b0); do_credit(4, 3);
        push("send_credit");

        // p0v0 tail ->0 DRAIN, p4v3 ->1.
        begin_cyc();
        do_send(0, 0, 1'b1); do_send(4, 3, 1'b0);
        ex_ca[0] = 1'b0;
        push("send4_tail");

        // p0v0 credit ->1, p4v3 ->0 (proves it held at 2).
        begin_cyc();
        do_credit(0, 0); do_send(4, 3, 1'b0);
        ex_ca[0] = 1'b1; ex_ca[19] = 1'b0;
        push("credit1");

        begin_cyc(); do_credit(0, 0); push("credit2");
        begin_cyc(); do_credit(0, 0); push("credit3");
        begin_cyc(); do_credit(0, 0); ex_av[0] = 1'b1; push("credit4");

        begin_cyc(); do_credit(4, 3); ex_ca[19] = 1'b1; push("p4v3_credit");

        // Credit to idle VC at full count: saturates, error.
        begin_cyc(); do_credit(0, 1); ex_err = ERR_EN; push("credit_sat");

        // Put p2v1 into DRAIN, then reset in the middle of it.
        begin_cyc(); do_alloc(2, 1); ex_av[9] = 1'b0; push("alloc_p2v1");
        begin_cyc(); do_send(2, 1, 1'b1); push("p2v1_drain");
        begin_cyc(); reset = 1'b0;
        ex_av = ALL; ex_ca = ALL; ex_err = 1'b0;
        push("reset_mid");
        begin_cyc(); reset = 1'b1; push("after_reset");

        // Send on a FREE VC: ignored, error.
        begin_cyc(); do_send(0, 2, 1'b0); ex_err = ERR_EN; push("send_free");
        begin_cyc(); reset = 1'b0; ex_err = 1'b0; push("reset_2");
        begin_cyc(); reset = 1'b1; push("idle_2");

        // Tail send and alloc of the same VC in one cycle: alloc rejected.
        begin_cyc(); do_alloc(1, 1); ex_av[5] = 1'b0; push("alloc_p1v1");
        begin_cyc(); do_send(1, 1, 1'b1); do_alloc(1, 1); ex_err = ERR_EN; push("tail_and_alloc");
        begin_cyc(); do_credit(1, 1); ex_av[5] = 1'b1; push("p1v1_free");
        begin_cyc(); push("final_idle");

        begin_cyc();
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_queue pending=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
